// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared state encoding, transfer sizes and wen-to-size helper
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Stores carry their size implicitly in the byte-lane enables.
  function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
    logic [1:0] sz;
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = SIZE_BYTE;
      4'b0011, 4'b1100:                   sz = SIZE_HALF;
      default:                            sz = SIZE_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/d_bridge_req_latch.sv
// rtl/d_bridge_req_latch.sv - request field capture register and live/latched request mux
module d_bridge_req_latch
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  capture,
  input  logic [DATA_W/8-1:0]   wen,
  input  logic [1:0]            size,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  req_wr,
  output logic [1:0]            req_size,
  output logic [ADDR_W-1:0]     req_addr,
  output logic [DATA_W-1:0]     req_wdata
);

  logic                live_wr;
  logic [1:0]          live_size;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  always_comb begin
    live_wr   = |wen;
    live_size = live_wr ? wen_to_size(wen) : size;
    wr_d      = capture ? live_wr   : wr_q;
    size_d    = capture ? live_size : size_q;
    addr_d    = capture ? addr      : addr_q;
    wdata_d   = capture ? wdata     : wdata_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // The issuing cycle drives the bus straight from the CPU; afterwards the copy holds it stable.
  always_comb begin
    req_wr    = capture ? live_wr   : wr_q;
    req_size  = capture ? live_size : size_q;
    req_addr  = capture ? addr      : addr_q;
    req_wdata = capture ? wdata     : wdata_q;
  end

endmodule

// File: rtl/d_sram_like_bridge.sv
// rtl/d_sram_like_bridge.sv - MEM-stage data_sram to sram-like bus bridge, one outstanding access
// Optional D_BRIDGE_PERF_CNT_EN adds a d_stall cycle counter output.
module d_sram_like_bridge
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
`ifdef D_BRIDGE_PERF_CNT_EN
  output logic [31:0]           perf_dstall_cycles,
`endif
  input  logic                  data_sram_en,
  input  logic [DATA_W/8-1:0]   data_sram_wen,
  input  logic [1:0]            data_sram_size,
  input  logic [ADDR_W-1:0]     data_sram_addr,
  input  logic [DATA_W-1:0]     data_sram_wdata,
  output logic [DATA_W-1:0]     data_sram_rdata,
  input  logic                  except_flush,
  input  logic                  longest_stall,
  output logic                  d_stall,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [1:0]            data_size,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [DATA_W-1:0]     data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [DATA_W-1:0]     data_rdata
);

  state_e              state_q, state_d;
  logic                kill_q, kill_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                issue;

  assign issue = (state_q == IDLE) && data_sram_en && !except_flush;

  d_bridge_req_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_latch (
    .clk       (clk),
    .resetn    (resetn),
    .capture   (issue),
    .wen       (data_sram_wen),
    .size      (data_sram_size),
    .addr      (data_sram_addr),
    .wdata     (data_sram_wdata),
    .req_wr    (data_wr),
    .req_size  (data_size),
    .req_addr  (data_addr),
    .req_wdata (data_wdata)
  );

  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    rdata_d  = rdata_q;
    data_req = 1'b0;
    d_stall  = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          data_req = 1'b1;
          d_stall  = 1'b1;
          state_d  = data_addr_ok ? WAIT : REQ;
        end
      end
      REQ: begin
        data_req = 1'b1;
        d_stall  = 1'b1;
        if (except_flush) kill_d = 1'b1;
        if (data_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        d_stall = 1'b1;
        if (data_data_ok) begin
          // A flush landing on the data_ok cycle discards the result just like an earlier one.
          if (kill_q || except_flush) begin
            kill_d  = 1'b0;
            state_d = IDLE;
          end else begin
            if (!data_wr) rdata_d = data_rdata;
            state_d = DONE;
          end
        end else if (except_flush) begin
          kill_d = 1'b1;
        end
      end
      DONE: begin
        if (!longest_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_sram_rdata = rdata_q;

`ifdef D_BRIDGE_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  assign perf_d = d_stall ? perf_q + 32'd1 : perf_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) perf_q <= 32'd0;
    else         perf_q <= perf_d;
  end

  assign perf_dstall_cycles = perf_q;
`endif

endmodule
